// File: rtl/and_qualifier_pkg.sv
// Shared types and defaults for the AND-tree output qualifier.
// The state encoding puts "qualified" states in the upper half, so bit 1 alone marks them.
package and_qualifier_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    ACTIVE = 2'd2,
    REL    = 2'd3
  } state_e;

  localparam logic [1:0] SUPPLY_OK = 2'b10;

  localparam int unsigned DEF_HOLD_CYCLES = 4;
  localparam int unsigned DEF_CNT_WIDTH   = 8;
  localparam int unsigned DEF_EVT_WIDTH   = 16;
  localparam int unsigned GLITCH_WIDTH    = 8;

  function automatic logic is_qualified(input state_e s);
    return (s == ACTIVE) || (s == REL);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous gate-chain outputs; latency is two clocks.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/and_qualifier.sv
// Synchronises, debounces and counts events on the raw AND-tree output.
// Build with AND_QUALIFIER_GLITCH_COUNT_EN to add the glitch_count output.
module and_qualifier
  import and_qualifier_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned EVT_WIDTH   = DEF_EVT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           DigitSupply,
  input  logic                 inputData,
  input  logic                 clear,
  output logic                 qualified,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [EVT_WIDTH-1:0] event_count
`ifdef AND_QUALIFIER_GLITCH_COUNT_EN
  ,
  output logic [GLITCH_WIDTH-1:0] glitch_count
`endif
);

  localparam logic                 HOLD_ONE  = (HOLD_CYCLES == 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic s;
  logic pwr_ok;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [EVT_WIDTH-1:0] evt_q, evt_d;
  logic                 abort;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (inputData),
    .q_o   (s)
  );

  assign pwr_ok = (DigitSupply == SUPPLY_OK);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    if (!pwr_ok) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (s) begin
            state_d = HOLD_ONE ? ACTIVE : QUAL;
            cnt_d   = HOLD_ONE ? '0 : CNT_ONE;
          end
        end
        QUAL: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
            abort   = 1'b1;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ACTIVE: begin
          cnt_d = '0;
          if (!s) begin
            state_d = HOLD_ONE ? IDLE : REL;
            cnt_d   = HOLD_ONE ? '0 : CNT_ONE;
          end
        end
        REL: begin
          if (s) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            abort   = 1'b1;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pulses are derived from the next state so they line up with the first
  // cycle qualified shows its new level; supply loss drops silently.
  always_comb begin
    rise_d = pwr_ok && is_qualified(state_d) && !is_qualified(state_q);
    fall_d = pwr_ok && !is_qualified(state_d) && is_qualified(state_q);
    evt_d  = evt_q;
    if (clear) begin
      evt_d = '0;
    end else if (rise_d && (evt_q != '1)) begin
      evt_d = evt_q + EVT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
    end
  end

  assign qualified   = is_qualified(state_q);
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign event_count = evt_q;

`ifdef AND_QUALIFIER_GLITCH_COUNT_EN
  logic [GLITCH_WIDTH-1:0] glitch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else if (clear) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != '1)) begin
      glitch_q <= glitch_q + GLITCH_WIDTH'(1);
    end
  end

  assign glitch_count = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_and_qualifier.sv
// Scoreboard bench for and_qualifier: expected pulse events are queued by the
// stimulus and retired by an independent monitor on the falling clock edge.
module tb_and_qualifier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  DigitSupply;
  logic        inputData;
  logic        clear;

  logic        qualified, rise_pulse, fall_pulse;
  logic [15:0] event_count;
  logic        qualified2, rise_pulse2, fall_pulse2;
  logic [1:0]  event_count2;
`ifdef AND_QUALIFIER_GLITCH_COUNT_EN
  logic [7:0]  glitch_count, glitch_count2;
`endif

  always #5 clk = ~clk;

  and_qualifier #(.HOLD_CYCLES(4), .CNT_WIDTH(8), .EVT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .DigitSupply (DigitSupply),
    .inputData   (inputData),
    .clear       (clear),
    .qualified   (qualified),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .event_count (event_count)
`ifdef AND_QUALIFIER_GLITCH_COUNT_EN
    ,
    .glitch_count(glitch_count)
`endif
  );

  and_qualifier #(.HOLD_CYCLES(4), .CNT_WIDTH(8), .EVT_WIDTH(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .DigitSupply (DigitSupply),
    .inputData   (inputData),
    .clear       (clear),
    .qualified   (qualified2),
    .rise_pulse  (rise_pulse2),
    .fall_pulse  (fall_pulse2),
    .event_count (event_count2)
`ifdef AND_QUALIFIER_GLITCH_COUNT_EN
    ,
    .glitch_count(glitch_count2)
`endif
  );

  typedef struct {
    bit          rise;
    int          cyc;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int unsigned exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input bit rise, input int at_cyc, input int unsigned cnt);
    exp_t e;
    e.rise = rise;
    e.cyc  = at_cyc;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  // Monitor: retires overdue expectations and matches every observed pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("pulse_missing_at_cycle", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (rise_pulse || fall_pulse) begin
        check("both_pulses", 32'(rise_pulse & fall_pulse), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, rise_pulse, fall_pulse}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          check("pulse_rise", 32'(rise_pulse), 32'(e.rise));
          check("pulse_fall", 32'(fall_pulse), 32'(!e.rise));
          check("pulse_event_count", 32'(event_count), e.cnt);
        end
      end
    end
  end

  initial begin
    int e;
    rst_n       = 1'b0;
    DigitSupply = 2'b10;
    inputData   = 1'b0;
    clear       = 1'b0;

    #3;
    check("reset_qualified", 32'(qualified), 32'd0);
    check("reset_rise", 32'(rise_pulse), 32'd0);
    check("reset_fall", 32'(fall_pulse), 32'd0);
    check("reset_event_count", 32'(event_count), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);

    // Clean rise: qualified six clocks after the input edge.
    e = cyc;
    inputData = 1'b1;
    exp_cnt = 1;
    expect_pulse(1'b1, e + 6, exp_cnt);
    step(5);
    check("rise_latency_early", 32'(qualified), 32'd0);
    step(1);
    check("rise_latency", 32'(qualified), 32'd1);
    check("rise_event_count", 32'(event_count), 32'd1);
    step(1);
    check("rise_pulse_width", 32'(rise_pulse), 32'd0);
    step(2);

    // Two-clock dropout while ACTIVE is absorbed.
    inputData = 1'b0;
    step(2);
    inputData = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch_hold_qualified", 32'(qualified), 32'd1);
    end
`ifdef AND_QUALIFIER_GLITCH_COUNT_EN
    check("glitch_count_one", 32'(glitch_count), 32'd1);
`endif

    // Release, then clear the counter.
    e = cyc;
    inputData = 1'b0;
    expect_pulse(1'b0, e + 6, exp_cnt);
    step(8);
    check("released", 32'(qualified), 32'd0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    exp_cnt = 0;
    check("clear_event_count", 32'(event_count), 32'd0);

    // Input toggling every two clocks never qualifies.
    for (int i = 0; i < 40; i++) begin
      inputData = ((i % 4) < 2);
      step(1);
      check("toggle_qualified", 32'(qualified), 32'd0);
    end
    inputData = 1'b0;
    step(4);
    check("toggle_event_count", 32'(event_count), 32'd0);
`ifdef AND_QUALIFIER_GLITCH_COUNT_EN
    check("toggle_glitch_count", 32'(glitch_count), 32'd10);
`endif

    // Supply loss while ACTIVE drops qualified with no fall pulse.
    e = cyc;
    inputData = 1'b1;
    exp_cnt = 1;
    expect_pulse(1'b1, e + 6, exp_cnt);
    step(8);
    check("pre_supply_qualified", 32'(qualified), 32'd1);
    DigitSupply = 2'b11;
    step(1);
    check("supply_off_qualified", 32'(qualified), 32'd0);
    check("supply_off_fall", 32'(fall_pulse), 32'd0);
    step(3);
    check("supply_off_hold", 32'(qualified), 32'd0);
    check("supply_off_event_count", 32'(event_count), 32'd1);
    e = cyc;
    DigitSupply = 2'b10;
    exp_cnt = 2;
    expect_pulse(1'b1, e + 4, exp_cnt);
    step(3);
    check("requal_early", 32'(qualified), 32'd0);
    step(1);
    check("requal", 32'(qualified), 32'd1);
    check("requal_event_count", 32'(event_count), 32'd2);

    // Saturation on the 2-bit counter instance, then clear racing a rise.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      e = cyc;
      inputData = 1'b0;
      expect_pulse(1'b0, e + 6, exp_cnt);
      step(8);
      e = cyc;
      inputData = 1'b1;
      exp_cnt++;
      expect_pulse(1'b1, e + 6, exp_cnt);
      step(8);
    end
    check("sat_event_count", 32'(event_count2), 32'd3);
    check("wide_event_count", 32'(event_count), 32'd5);
    e = cyc;
    inputData = 1'b0;
    expect_pulse(1'b0, e + 6, exp_cnt);
    step(8);
    e = cyc;
    inputData = 1'b1;
    exp_cnt = 0;
    expect_pulse(1'b1, e + 6, exp_cnt);
    step(5);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_wins_qualified", 32'(qualified2), 32'd1);
    check("clear_wins_sat", 32'(event_count2), 32'd0);
    check("clear_wins_wide", 32'(event_count), 32'd0);
    step(2);

    // Build a non-zero count, then reset in the middle of QUAL.
    e = cyc;
    inputData = 1'b0;
    expect_pulse(1'b0, e + 6, exp_cnt);
    step(8);
    e = cyc;
    inputData = 1'b1;
    exp_cnt = 1;
    expect_pulse(1'b1, e + 6, exp_cnt);
    step(8);
    e = cyc;
    inputData = 1'b0;
    expect_pulse(1'b0, e + 6, exp_cnt);
    step(8);
    check("pre_reset_event_count", 32'(event_count), 32'd1);
    inputData = 1'b1;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("midqual_reset_qualified", 32'(qualified), 32'd0);
    check("midqual_reset_rise", 32'(rise_pulse), 32'd0);
    check("midqual_reset_event_count", 32'(event_count), 32'd0);
    check("midqual_reset_event_count2", 32'(event_count2), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = cyc;
    exp_cnt = 1;
    expect_pulse(1'b1, e + 6, exp_cnt);
    step(5);
    check("post_reset_early", 32'(qualified), 32'd0);
    step(1);
    check("post_reset_qualified", 32'(qualified), 32'd1);
    check("post_reset_event_count", 32'(event_count), 32'd1);

    step(10);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/and_qualifier.md
Name: and_qualifier

Overview:
- Sequential stage directly downstream of the multi-input AND chain.
- Takes the raw, possibly glitchy `outputData` of that AND tree as its `inputData`.
- Synchronises it, debounces it, and publishes a qualified level, rise/fall pulses and a saturating event count.
- Gated by the same two-rail `DigitSupply` convention used by the gate cells.

Parameters:
- HOLD_CYCLES, 4: consecutive synchronised-high (or -low) cycles required to assert (or release) `qualified`; legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 8: width of the hold counter.
- EVT_WIDTH, 16: width of `event_count`.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- DigitSupply  input  2  supply rails; valid only when [1]=1, [0]=0 (2'b10)
- inputData  input  1  raw AND-tree result, asynchronous to clk
- clear  input  1  synchronous clear of `event_count` (and `glitch_count` if built)
- qualified  output  1  debounced level
- rise_pulse  output  1  one-cycle pulse when `qualified` goes 0->1
- fall_pulse  output  1  one-cycle pulse when `qualified` goes 1->0
- event_count  output  EVT_WIDTH  number of qualified rising events, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): synchroniser flops=0, state=IDLE, hold counter=0, all outputs 0.
- Synchroniser: two flops on `inputData`; `s` is the second-flop output. Latency is 2 cycles.
- `pwr_ok` = (DigitSupply==2'b10).
  - While `pwr_ok`=0: the synchroniser still samples, the FSM is forced to IDLE, the counter is zeroed, and `qualified` and both pulses are 0.
  - `event_count` holds its value.
- FSM, state encodings IDLE=0, QUAL=1, ACTIVE=2, REL=3:
  - IDLE: s=1 -> QUAL, cnt=1. If HOLD_CYCLES==1, go straight to ACTIVE instead.
  - QUAL: s=0 -> IDLE, cnt=0 (an abort). s=1 and cnt==HOLD_CYCLES-1 -> ACTIVE. Otherwise cnt+1.
  - ACTIVE: s=0 -> REL, cnt=1. If HOLD_CYCLES==1, go straight to IDLE.
  - REL: s=1 -> ACTIVE, cnt=0 (`qualified` stays 1, no pulses). s=0 and cnt==HOLD_CYCLES-1 -> IDLE. Otherwise cnt+1.
- `qualified` is a registered output, 1 in ACTIVE and REL.
- Latency: a stable input edge reaches `qualified` after 2+HOLD_CYCLES clocks.
- rise_pulse / fall_pulse:
  - Registered and asserted in the first cycle `qualified` shows its new value.
  - Never both set in the same cycle.
  - Never asserted while `pwr_ok`=0. Loss of supply while ACTIVE drops `qualified` silently, with no `fall_pulse`.
- event_count:
  - Increments on each `rise_pulse` cycle and saturates at 2^EVT_WIDTH-1.
  - `clear`=1 sets it to 0. If `clear` and a rise occur in the same cycle, `clear` wins and the result is 0, not 1.
- Reset mid-qualification aborts immediately. After deassertion, a high input requires the full 2+HOLD_CYCLES cycles again.

Optional Feature:
- Macro: AND_QUALIFIER_GLITCH_COUNT_EN.
- Defined:
  - Adds output `glitch_count`, 8 bits.
  - Increments on each QUAL->IDLE or REL->ACTIVE abort and saturates at 255.
  - Cleared by reset and by `clear`.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `and_qualifier_pkg`:
  - State typedef/localparams IDLE..REL.
  - SUPPLY_OK constant 2'b10.
  - Default widths.
- Sub-module `sync_2ff`: two-flop synchroniser with async active-low reset; reusable for other gate-chain outputs.

Test Plan:
- HOLD_CYCLES=4, DigitSupply=2'b10, drive inputData 0->1 and hold -> `qualified` rises exactly 6 clocks later, one-cycle `rise_pulse`, `event_count`=1.
- While ACTIVE, pull inputData low for 2 clocks then high -> no `fall_pulse`, `qualified` stays 1; with the macro defined, `glitch_count`=1.
- Toggle inputData every 2 clocks for 40 clocks -> `qualified` stays 0, `event_count`=0.
- DigitSupply=2'b11 while ACTIVE -> `qualified`=0 next cycle, no pulses; restore 2'b10 with input high -> re-qualifies after HOLD_CYCLES clocks, `event_count`+1.
- EVT_WIDTH=2, produce 5 qualified rises -> `event_count` saturates at 3. Then assert `clear` in the same cycle as a rise -> `event_count`=0.
- Assert rst_n=0 asynchronously mid-QUAL (cnt=2) -> all outputs 0 immediately; after release, 6 clocks are needed to qualify again.
